vec_stim_sequencer: RTL

- Hardware replacement for the bench-side stimulus counter. Drives the 6-bit `switch` bus of the chapter-2 vector datapaths on the board.
- Three modes: hold, manual single-step from a push button, and auto-step from a prescaled tick.
- Sits between the board buttons/switches and the datapath's `switch` input. The datapath's `led` output stays on the board LEDs.

---
 rtl/vec_guide_pkg.sv | 35 +++
 rtl/btn_debounce.sv | 64 ++++++
 rtl/vec_stim_sequencer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/vec_guide_pkg.sv
// -----------------------------------------------------------------------------
// vec_guide_pkg
// Shared definitions for the chapter-2 vector datapath board tops.
//   - mode_t       : stimulus sequencer mode encoding (drives mode_led directly)
//   - next_mode()  : HOLD -> MANUAL -> AUTO -> HOLD rotation
//   - DEFAULT_*    : board defaults (6-bit switch bus, 50 MHz clock)
// -----------------------------------------------------------------------------
package vec_guide_pkg;

    // Board clock and derived defaults.
    localparam int unsigned CLK_HZ            = 50_000_000;
    localparam int unsigned DEFAULT_WIDTH     = 6;
    // One automatic step per second.
    localparam int unsigned DEFAULT_TICK_DIV  = CLK_HZ;
    // 20 ms of stable input before a button level is believed.
    localparam int unsigned DEFAULT_DB_CYCLES = CLK_HZ / 50;

    // Encoding is visible on the board LEDs, so the values are fixed.
    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_MANUAL = 2'b01,
        MODE_AUTO   = 2'b10
    } mode_t;

    // Mode rotation on each mode-button press. The unused encoding 2'b11
    // falls back to HOLD.
    function automatic mode_t next_mode(input mode_t m);
        case (m)
            MODE_HOLD:   next_mode = MODE_MANUAL;
            MODE_MANUAL: next_mode = MODE_AUTO;
            default:     next_mode = MODE_HOLD;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Synchronizes a raw asynchronous push button into the clk domain and filters
// contact bounce.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   raw    : raw button input, asynchronous, active-high
//   level  : debounced button level
//   press  : one-cycle strobe on the debounced rising edge (none on release)
//
// The debounced level follows the synchronized input only after the two have
// differed for DB_CYCLES consecutive cycles; a single agreeing cycle restarts
// the count. From a clean raw rising edge, press rises DB_CYCLES+2 cycles
// later (two synchronizer stages plus DB_CYCLES of filtering).
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press
);

    // 24 bits covers the full legal DB_CYCLES range.
    localparam int unsigned CNT_W   = 24;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] db_cnt;

    // NOTE: non-blocking assignments throughout, so each flop samples the
    // value its neighbour held before the edge; this is what makes the
    // two synchronizer stages really two stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            db_cnt <= '0;
            level  <= 1'b0;
            press  <= 1'b0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            press  <= 1'b0;
            if (sync_2 != level) begin
                // db_cnt holds how many disagreeing cycles have already been
                // seen; this cycle is the DB_CYCLES-th one when it hits DB_LAST.
                if (db_cnt == DB_LAST) begin
                    level  <= sync_2;
                    press  <= sync_2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/vec_stim_sequencer.sv
// -----------------------------------------------------------------------------
// vec_stim_sequencer
// Stimulus generator for the 6-bit `switch` bus of the chapter-2 vector
// datapaths. Replaces the bench-side stimulus counter on the board.
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   btn_step   : raw step button (async, active-high)
//   btn_mode   : raw mode button (async, active-high)
//   load       : synchronous level, loads sw_preset into the counter
//   sw_preset  : preset value for load
//   switch_out : stimulus vector to the datapath `switch` input
//   mode_led   : current mode, 00 HOLD / 01 MANUAL / 10 AUTO
//   step_pulse : one-cycle strobe, high in the cycle switch_out shows a value
//                produced by a step press or an auto tick (never for load)
//
// Modes rotate HOLD -> MANUAL -> AUTO -> HOLD on each mode press. In MANUAL a
// step press increments the counter; in AUTO a prescaled tick does, every
// TICK_DIV cycles. Step presses in other modes are dropped. load overrides
// both increment sources in every mode. The counter wraps modulo 2^WIDTH.
// -----------------------------------------------------------------------------
module vec_stim_sequencer
    import vec_guide_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned TICK_DIV  = DEFAULT_TICK_DIV,
    parameter int unsigned DB_CYCLES = DEFAULT_DB_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_step,
    input  logic             btn_mode,
    input  logic             load,
    input  logic [WIDTH-1:0] sw_preset,
    output logic [WIDTH-1:0] switch_out,
    output logic [1:0]       mode_led,
    output logic             step_pulse
);

    localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);

    mode_t       state;
    logic [31:0] presc;
    logic        tick;
    logic        advance;

    logic        step_press;
    logic        mode_press;
    logic        step_level;
    logic        mode_level;
    logic        unused_levels;

    // -------------------------------------------------------------------------
    // Button conditioning
    // -------------------------------------------------------------------------
    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_step_db (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_step),
        .level (step_level),
        .press (step_press)
    );

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_mode_db (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_mode),
        .level (mode_level),
        .press (mode_press)
    );

    // Only the press strobes are used here; the levels are kept on the
    // debouncer interface for other board tops.
    assign unused_levels = step_level ^ mode_level;

    // -------------------------------------------------------------------------
    // Mode FSM. mode_led is loaded with the same next value as state, so the
    // LEDs show the new mode in the same cycle the state takes it.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= MODE_HOLD;
            mode_led <= MODE_HOLD;
        end else if (mode_press) begin
            state    <= next_mode(state);
            mode_led <= next_mode(state);
        end
    end

    // -------------------------------------------------------------------------
    // Prescaler. Held at 0 outside AUTO so the first tick lands exactly
    // TICK_DIV cycles after AUTO is entered. load does not touch it.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (state != MODE_AUTO) begin
            presc <= '0;
        end else if (presc == TICK_LAST) begin
            presc <= '0;
        end else begin
            presc <= presc + 32'd1;
        end
    end

    assign tick = (state == MODE_AUTO) && (presc == TICK_LAST);

    // -------------------------------------------------------------------------
    // Counter. The increment decision uses the current (pre-transition) state,
    // so a tick in the cycle AUTO is left still counts.
    // -------------------------------------------------------------------------
    // NOTE: every always_comb output gets a default before any condition so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        advance = 1'b0;
        if (!load) begin
            advance = ((state == MODE_MANUAL) && step_press) || tick;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            switch_out <= '0;
            step_pulse <= 1'b0;
        end else if (load) begin
            switch_out <= sw_preset;
            step_pulse <= 1'b0;
        end else if (advance) begin
            // Modulo 2^WIDTH: all-ones wraps to zero and still strobes.
            switch_out <= switch_out + WIDTH'(1);
            step_pulse <= 1'b1;
        end else begin
            step_pulse <= 1'b0;
        end
    end

endmodule
